// File: rtl/ram_pkg.sv
// Shared types and constants for the two-requester RAM access arbiter.
// Word geometry, read/write encoding and controller state encoding.
package ram_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester handshakes and RAM control bus shared by the arbiter and its environment.
// The slave modport is the arbiter's view; master is the requesters/RAM side.
interface ram_access_arbiter_if;

  logic                      req0_valid;
  logic                      req0_write;
  logic [ram_pkg::ADDR_W-1:0] req0_addr;
  logic [ram_pkg::DATA_W-1:0] req0_wdata;
  logic                      req0_ready;
  logic                      req0_done;
  logic [ram_pkg::DATA_W-1:0] req0_rdata;

  logic                      req1_valid;
  logic                      req1_write;
  logic [ram_pkg::ADDR_W-1:0] req1_addr;
  logic [ram_pkg::DATA_W-1:0] req1_wdata;
  logic                      req1_ready;
  logic                      req1_done;
  logic [ram_pkg::DATA_W-1:0] req1_rdata;

  logic                      mem_en;
  logic                      mem_rw;
  logic [ram_pkg::ADDR_W-1:0] mem_addr;
  logic [ram_pkg::DATA_W-1:0] mem_wdata;
  logic [ram_pkg::DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, req0_done, req0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_done, req1_rdata,
    output mem_en, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, req0_done, req0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_done, req1_rdata,
    input  mem_en, mem_rw, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a tie goes to the requester named by prio.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    if (valid == 2'b11) grant = prio ? 2'b10 : 2'b01;
    else                grant = valid;
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one small RAM between two requesters: round-robin accept, one RAM
// access cycle, then a completion pulse carrying read data to the owner.
module ram_access_arbiter
  import ram_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  ram_access_arbiter_if.slave bus
);

  state_t              state, state_nxt;
  logic                prio;
  logic                own;
  logic                cap_rw;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [DATA_W-1:0]   cap_rdata;
  logic [1:0]          valid;
  logic [1:0]          grant;
  logic                accept;

  assign valid = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_arb (
    .valid (valid),
    .prio  (prio),
    .grant (grant)
  );

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.req0_done  = 1'b0;
    bus.req1_done  = 1'b0;
    bus.req0_rdata = '0;
    bus.req1_rdata = '0;
    bus.mem_en     = 1'b0;
    bus.mem_rw     = RW_READ;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    unique case (state)
      IDLE: begin
        // ready is combinational from valid, so it is gated to stay low while reset is held
        if ((|valid) && rst_n) begin
          accept         = 1'b1;
          bus.req0_ready = grant[0];
          bus.req1_ready = grant[1];
          state_nxt      = ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_en    = 1'b1;
        bus.mem_rw    = cap_rw;
        bus.mem_addr  = cap_addr;
        bus.mem_wdata = cap_wdata;
        state_nxt     = DONE;
      end
      DONE: begin
        bus.req0_done  = !own;
        bus.req1_done  = own;
        bus.req0_rdata = own ? '0 : cap_rdata;
        bus.req1_rdata = own ? cap_rdata : '0;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= 1'b0;
      own       <= 1'b0;
      cap_rw    <= RW_READ;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_rdata <= '0;
    end else begin
      if (accept) begin
        // pointer moves to whichever requester just lost (or was absent)
        prio      <= grant[0];
        own       <= grant[1];
        cap_rw    <= grant[1] ? bus.req1_write : bus.req0_write;
        cap_addr  <= grant[1] ? bus.req1_addr  : bus.req0_addr;
        cap_wdata <= grant[1] ? bus.req1_wdata : bus.req0_wdata;
      end
      if (state == ACCESS) begin
        cap_rdata <= (cap_rw == RW_READ) ? bus.mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural RAM, a reference
// memory and an in-order scoreboard of expected completions.
module tb_ram_access_arbiter;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_access_arbiter_if bus ();

  ram_access_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] ram [4];
  always @(posedge clk)
    if (bus.mem_en && bus.mem_rw == RW_WRITE) ram[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = ram[bus.mem_addr];

  typedef struct {
    int                id;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] ref_mem [4];
  int                checks = 0;
  int                errors = 0;
  int                cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done,
            bus.req0_rdata, bus.req1_rdata, bus.mem_en, bus.mem_rw,
            bus.mem_addr, bus.mem_wdata};
  endfunction

  function automatic logic rdy(input int id);
    return (id == 1) ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic dn(input int id);
    return (id == 1) ? bus.req1_done : bus.req0_done;
  endfunction

  task automatic drive(input int id, input logic v, input logic w,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  // Expectations are queued in the order the arbiter is required to serve them.
  task automatic expect_op(input int id, input logic wr,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    e.id = id;
    if (wr) begin
      ref_mem[a] = d;
      e.rdata    = '0;
    end else begin
      e.rdata = ref_mem[a];
    end
    sb.push_back(e);
  endtask

  task automatic pop_done(input string tag);
    exp_t e;
    int   who;
    who = bus.req1_done ? 1 : 0;
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_owner"}, who, e.id);
      check({tag, "_single_done"}, bus.req0_done & bus.req1_done, 0);
      check({tag, "_rdata"}, (who == 1) ? bus.req1_rdata : bus.req0_rdata, e.rdata);
      check({tag, "_other_rdata"}, (who == 1) ? bus.req0_rdata : bus.req1_rdata, 0);
    end
  endtask

  task automatic wait_ready(input int id, input string tag, output int t);
    int n = 0;
    while (!rdy(id) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_ready"}, rdy(id), 1);
    t = cyc;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(bus.req0_done || bus.req1_done) && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, bus.req0_done | bus.req1_done, 1);
    if (bus.req0_done || bus.req1_done) pop_done(tag);
    else if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic op(input int id, input logic wr, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d, input string tag);
    int t0;
    expect_op(id, wr, a, d);
    @(negedge clk); drive(id, 1'b1, wr, a, d); #1;
    wait_ready(id, tag, t0);
    check({tag, "_other_ready"}, rdy(1 - id), 0);
    @(negedge clk); drive(id, 1'b0, 1'b0, '0, '0); #1;
    check({tag, "_mem"}, {bus.mem_en, bus.mem_rw, bus.mem_addr, bus.mem_wdata},
          {1'b1, wr, a, d});
    @(negedge clk); #1;
    check({tag, "_done_latency"}, dn(id), 1);
    wait_done(tag);
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", outs(), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int t0, t1, seen, viol;
    int gseq[$];
    int gtime[$];

    for (int i = 0; i < 4; i++) begin
      ram[i]     = DATA_W'(8 + i);
      ref_mem[i] = DATA_W'(8 + i);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    check("reset_async_t0", outs(), 0);
    do_reset();

    // Single write then read on req0
    op(0, RW_WRITE, 2'd2, 4'hA, "wr0");
    op(0, RW_READ,  2'd2, 4'h0, "rd0");

    // Contention from reset: req0 reads old word, then req1 writes 5
    do_reset();
    expect_op(0, RW_READ,  2'd1, 4'h0);
    expect_op(1, RW_WRITE, 2'd1, 4'h5);
    @(negedge clk);
    drive(0, 1'b1, RW_READ,  2'd1, 4'h0);
    drive(1, 1'b1, RW_WRITE, 2'd1, 4'h5);
    #1;
    check("cont_first_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    t0 = cyc;
    @(negedge clk); drive(0, 1'b0, 1'b0, '0, '0); #1;
    check("cont_acc_rd", {bus.mem_en, bus.mem_rw, bus.mem_addr, bus.req1_ready},
          {1'b1, RW_READ, 2'd1, 1'b0});
    @(negedge clk); #1;
    wait_done("cont_rd0");
    @(negedge clk); #1;
    wait_ready(1, "cont_r1", t1);
    check("cont_r1_gap", t1 - t0, 3);
    @(negedge clk); drive(1, 1'b0, 1'b0, '0, '0); #1;
    check("cont_acc_wr", {bus.mem_en, bus.mem_rw, bus.mem_addr, bus.mem_wdata},
          {1'b1, RW_WRITE, 2'd1, 4'h5});
    @(negedge clk); #1;
    wait_done("cont_wr1");
    op(0, RW_READ, 2'd1, 4'h0, "cont_rd_new");

    // Fairness: both held valid until four grants
    do_reset();
    expect_op(0, RW_READ, 2'd0, 4'h0);
    expect_op(1, RW_READ, 2'd3, 4'h0);
    expect_op(0, RW_READ, 2'd0, 4'h0);
    expect_op(1, RW_READ, 2'd3, 4'h0);
    @(negedge clk);
    drive(0, 1'b1, RW_READ, 2'd0, 4'h0);
    drive(1, 1'b1, RW_READ, 2'd3, 4'h0);
    #1;
    for (int i = 0; i < 12; i++) begin
      if (bus.req0_ready) begin gseq.push_back(0); gtime.push_back(cyc); end
      if (bus.req1_ready) begin gseq.push_back(1); gtime.push_back(cyc); end
      if (bus.req0_done || bus.req1_done) pop_done("fair");
      @(negedge clk); #1;
      if (gseq.size() == 4) begin
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
      end
    end
    check("fair_grant_count", gseq.size(), 4);
    check("fair_sb_drained", sb.size(), 0);
    if (gseq.size() == 4) begin
      for (int i = 0; i < 4; i++) check("fair_grant_order", gseq[i], i % 2);
      for (int k = 0; k < 2; k++) check("fair_r1_wait", gtime[2*k+1] - gtime[2*k], 3);
    end

    // req1 alone, continuously valid
    sb.delete();
    gtime.delete();
    viol = 0;
    for (int i = 0; i < 3; i++) expect_op(1, RW_READ, 2'd2, 4'h0);
    @(negedge clk); drive(1, 1'b1, RW_READ, 2'd2, 4'h0); #1;
    for (int i = 0; i < 10; i++) begin
      if ({bus.req0_ready, bus.req0_done, bus.req0_rdata} != '0) viol++;
      if (bus.req1_ready) gtime.push_back(cyc);
      if (bus.req1_done) pop_done("solo");
      @(negedge clk); #1;
      if (gtime.size() == 3) drive(1, 1'b0, 1'b0, '0, '0);
    end
    check("solo_ready_count", gtime.size(), 3);
    check("solo_req0_quiet", viol, 0);
    check("solo_sb_drained", sb.size(), 0);
    if (gtime.size() == 3) begin
      check("solo_period_a", gtime[1] - gtime[0], 3);
      check("solo_period_b", gtime[2] - gtime[1], 3);
    end

    // Reset while req1's read is in ACCESS
    sb.delete();
    @(negedge clk); drive(1, 1'b1, RW_READ, 2'd2, 4'h0); #1;
    wait_ready(1, "rst_op", t0);
    @(negedge clk); drive(1, 1'b0, 1'b0, '0, '0); #1;
    check("rst_in_access", bus.mem_en, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", outs(), 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (bus.req1_done || outs() != '0) seen++;
    end
    check("rst_no_done", seen, 0);
    rst_n = 1'b1;
    expect_op(0, RW_READ, 2'd3, 4'h0);
    expect_op(1, RW_READ, 2'd2, 4'h0);
    @(negedge clk);
    drive(0, 1'b1, RW_READ, 2'd3, 4'h0);
    drive(1, 1'b1, RW_READ, 2'd2, 4'h0);
    #1;
    check("rst_prio_zero", {bus.req1_ready, bus.req0_ready}, 2'b01);
    @(negedge clk); drive(0, 1'b0, 1'b0, '0, '0); #1;
    @(negedge clk); #1;
    wait_done("rst_post0");
    @(negedge clk); #1;
    wait_ready(1, "rst_post1", t1);
    @(negedge clk); drive(1, 1'b0, 1'b0, '0, '0); #1;
    @(negedge clk); #1;
    wait_done("rst_post1");

    // Fill via alternating requesters, then read back crosswise
    op(0, RW_WRITE, 2'd0, 4'h1, "fill0");
    op(1, RW_WRITE, 2'd1, 4'h2, "fill1");
    op(0, RW_WRITE, 2'd2, 4'h3, "fill2");
    op(1, RW_WRITE, 2'd3, 4'h4, "fill3");
    op(1, RW_READ,  2'd0, 4'h0, "back0");
    op(0, RW_READ,  2'd1, 4'h0, "back1");
    op(1, RW_READ,  2'd2, 4'h0, "back2");
    op(0, RW_READ,  2'd3, 4'h0, "back3");
    check("final_sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
